// File: rtl/aemb2_bus_ctrl.sv
// AEMB2 memory-stage bus sequencer: launches DWB/CWB cycles and stalls the pipe until ack.
// Optional cycle timeout is compiled in with AEMB2_BUS_TIMEOUT_EN.
module aemb2_bus_ctrl #(
    parameter bit          TXE = 1'b1,
    parameter int unsigned TMO = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_siz_i,
    input  logic [31:0] mem_adr_i,
    input  logic        fsl_req_i,
    input  logic        fsl_we_i,
    input  logic [3:0]  fsl_id_i,
    output logic [29:0] dwb_adr_o,
    output logic        dwb_stb_o,
    output logic        dwb_wre_o,
    output logic [3:0]  dwb_sel_o,
    input  logic        dwb_ack_i,
    output logic [3:0]  cwb_adr_o,
    output logic        cwb_stb_o,
    output logic        cwb_wre_o,
    input  logic        cwb_ack_i,
    output logic        ena_o,
    output logic        pha_o,
    output logic [3:0]  sel_ma_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DBUS,
        ST_CBUS
    } state_t;

    state_t      r_state;
    state_t      w_nxt;

    logic [29:0] r_dadr;
    logic        r_dwre;
    logic [3:0]  r_dsel;
    logic [3:0]  r_cadr;
    logic        r_cwre;
    logic [3:0]  r_selma;
    logic        r_pha;

    logic [3:0]  w_sel;
    logic        w_idle;
    logic        w_ack;
    logic        w_tmo;

    assign w_idle = (r_state == ST_IDLE);

    // Only the ack of the bus actually being driven can end a cycle.
    assign w_ack = ((r_state == ST_DBUS) && dwb_ack_i) ||
                   ((r_state == ST_CBUS) && cwb_ack_i);

    // Big-endian lane select: byte 0 of a word lives on lane 3.
    always_comb begin
        w_sel = 4'hF;
        case (mem_siz_i)
            2'd0:    w_sel = 4'b1000 >> mem_adr_i[1:0];
            2'd1:    w_sel = mem_adr_i[1] ? 4'h3 : 4'hC;
            default: w_sel = 4'hF;
        endcase
    end

`ifdef AEMB2_BUS_TIMEOUT_EN
    localparam logic [7:0] LP_LAST = 8'(TMO - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    // An ack on the final cycle takes precedence over the timeout.
    assign w_tmo = !w_idle && !w_ack && (r_cnt == LP_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (w_idle) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_tmo = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_req_i) begin
                    w_nxt = ST_DBUS;
                end else if (fsl_req_i) begin
                    w_nxt = ST_CBUS;
                end
            end
            ST_DBUS, ST_CBUS: begin
                if (w_ack || w_tmo) begin
                    w_nxt = ST_IDLE;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Request fields are captured only when the pipe is enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_dadr  <= 30'd0;
            r_dwre  <= 1'b0;
            r_dsel  <= 4'd0;
            r_cadr  <= 4'd0;
            r_cwre  <= 1'b0;
            r_selma <= 4'd0;
            r_pha   <= 1'b0;
        end else if (w_idle) begin
            if (TXE) begin
                r_pha <= ~r_pha;
            end
            if (mem_req_i) begin
                r_dadr  <= mem_adr_i[31:2];
                r_dwre  <= mem_we_i;
                r_dsel  <= w_sel;
                r_selma <= w_sel;
            end else if (fsl_req_i) begin
                r_cadr  <= fsl_id_i;
                r_cwre  <= fsl_we_i;
                r_selma <= 4'd0;
            end
        end
    end

    assign dwb_adr_o = r_dadr;
    assign dwb_stb_o = (r_state == ST_DBUS);
    assign dwb_wre_o = r_dwre;
    assign dwb_sel_o = r_dsel;
    assign cwb_adr_o = r_cadr;
    assign cwb_stb_o = (r_state == ST_CBUS);
    assign cwb_wre_o = r_cwre;
    assign ena_o     = w_idle;
    assign pha_o     = r_pha;
    assign sel_ma_o  = r_selma;

endmodule

// File: tb/tb_aemb2_bus_ctrl.sv
// Bench for aemb2_bus_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model.
module tb_aemb2_bus_ctrl;

    localparam bit TXE = 1'b1;
    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_siz_i = 2'd0;
    logic [31:0] mem_adr_i = 32'd0;
    logic        fsl_req_i = 1'b0;
    logic        fsl_we_i = 1'b0;
    logic [3:0]  fsl_id_i = 4'd0;
    logic [29:0] dwb_adr_o;
    logic        dwb_stb_o;
    logic        dwb_wre_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_ack_i = 1'b0;
    logic [3:0]  cwb_adr_o;
    logic        cwb_stb_o;
    logic        cwb_wre_o;
    logic        cwb_ack_i = 1'b0;
    logic        ena_o;
    logic        pha_o;
    logic [3:0]  sel_ma_o;
    logic        err_o;

    aemb2_bus_ctrl #(.TXE(TXE), .TMO(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_siz_i(mem_siz_i), .mem_adr_i(mem_adr_i),
        .fsl_req_i(fsl_req_i), .fsl_we_i(fsl_we_i), .fsl_id_i(fsl_id_i),
        .dwb_adr_o(dwb_adr_o), .dwb_stb_o(dwb_stb_o), .dwb_wre_o(dwb_wre_o),
        .dwb_sel_o(dwb_sel_o), .dwb_ack_i(dwb_ack_i),
        .cwb_adr_o(cwb_adr_o), .cwb_stb_o(cwb_stb_o), .cwb_wre_o(cwb_wre_o),
        .cwb_ack_i(cwb_ack_i),
        .ena_o(ena_o), .pha_o(pha_o), .sel_ma_o(sel_ma_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: 0 = no cycle outstanding, 1 = data bus, 2 = FSL bus.
    int          m_busy = 0;
    int          m_cnt = 0;
    logic [29:0] m_dadr = '0;
    logic        m_dwe = 1'b0;
    logic [3:0]  m_dsel = '0;
    logic [3:0]  m_cid = '0;
    logic        m_cwe = 1'b0;
    logic [3:0]  m_selma = '0;
    logic        m_pha = 1'b0;
    logic        m_err = 1'b0;

    function automatic logic [3:0] sel_of(input logic [1:0] siz, input logic [1:0] a);
        if (siz == 2'd0) return 4'(8 >> a);
        if (siz == 2'd1) return a[1] ? 4'h3 : 4'hC;
        return 4'hF;
    endfunction

    always @(posedge clk_i) begin
        if (!rst_i) begin
            m_busy = 0; m_cnt = 0;
            m_dadr = '0; m_dwe = 0; m_dsel = '0;
            m_cid = '0; m_cwe = 0; m_selma = '0;
            m_pha = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_busy == 0) begin
                if (TXE) m_pha = ~m_pha;
                if (mem_req_i) begin
                    m_busy = 1; m_cnt = 0;
                    m_dadr = mem_adr_i[31:2];
                    m_dwe = mem_we_i;
                    m_dsel = sel_of(mem_siz_i, mem_adr_i[1:0]);
                    m_selma = m_dsel;
                end else if (fsl_req_i) begin
                    m_busy = 2; m_cnt = 0;
                    m_cid = fsl_id_i;
                    m_cwe = fsl_we_i;
                    m_selma = 4'd0;
                end
            end else if ((m_busy == 1 && dwb_ack_i) || (m_busy == 2 && cwb_ack_i)) begin
                m_busy = 0;
            end else begin
                m_cnt++;
`ifdef AEMB2_BUS_TIMEOUT_EN
                if (m_cnt == TMO) begin
                    m_busy = 0;
                    m_err = 1;
                end
`endif
            end
        end
    end

    always @(negedge clk_i) begin
        chk("ena", ena_o, m_busy == 0);
        chk("dwb_stb", dwb_stb_o, m_busy == 1);
        chk("cwb_stb", cwb_stb_o, m_busy == 2);
        chk("sel_ma", sel_ma_o, m_selma);
        chk("pha", pha_o, m_pha);
        chk("err", err_o, m_err);
        if (m_busy == 1) begin
            chk("dwb_adr", dwb_adr_o, m_dadr);
            chk("dwb_wre", dwb_wre_o, m_dwe);
            chk("dwb_sel", dwb_sel_o, m_dsel);
        end
        if (m_busy == 2) begin
            chk("cwb_adr", cwb_adr_o, m_cid);
            chk("cwb_wre", cwb_wre_o, m_cwe);
        end
    end

    task automatic cyc(input logic rst, input logic mreq, input logic mwe,
                       input logic [1:0] siz, input logic [31:0] adr,
                       input logic freq, input logic fwe, input logic [3:0] id,
                       input logic dack, input logic cack);
        @(negedge clk_i);
        rst_i = rst; mem_req_i = mreq; mem_we_i = mwe;
        mem_siz_i = siz; mem_adr_i = adr;
        fsl_req_i = freq; fsl_we_i = fwe; fsl_id_i = id;
        dwb_ack_i = dack; cwb_ack_i = cack;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic dack, input logic cack);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, dack, cack);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst dwb_stb", dwb_stb_o, 0);
        chk("rst cwb_stb", cwb_stb_o, 0);
        chk("rst ena", ena_o, 1);
        chk("rst pha", pha_o, 0);
        chk("rst sel_ma", sel_ma_o, 0);
        chk("rst dwb_adr", dwb_adr_o, 0);
        chk("rst err", err_o, 0);

        idle(0, 0); chk("pha1", pha_o, 1);
        idle(0, 0); chk("pha2", pha_o, 0);
        idle(0, 0); chk("pha3", pha_o, 1);

        cyc(1, 1, 0, 2'd0, 32'h1003, 0, 0, 0, 0, 0);
        chk("lb stb", dwb_stb_o, 1);
        chk("lb adr", dwb_adr_o, 32'h400);
        chk("lb sel", dwb_sel_o, 1);
        chk("lb sel_ma", sel_ma_o, 1);
        chk("lb ena", ena_o, 0);
        idle(0, 0); chk("lb stall2 ena", ena_o, 0);
        idle(0, 0); chk("lb stall3 ena", ena_o, 0);
        idle(1, 0);
        chk("lb done stb", dwb_stb_o, 0);
        chk("lb done ena", ena_o, 1);
        chk("lb hold sel_ma", sel_ma_o, 1);
        chk("lb pha held", pha_o, 0);

        cyc(1, 1, 1, 2'd1, 32'h22, 0, 0, 0, 0, 0);
        chk("sh stb", dwb_stb_o, 1);
        chk("sh wre", dwb_wre_o, 1);
        chk("sh sel", dwb_sel_o, 3);
        chk("sh adr", dwb_adr_o, 8);
        idle(1, 0);
        chk("sh done stb", dwb_stb_o, 0);
        chk("sh done ena", ena_o, 1);
        idle(1, 0);
        chk("spurious stb", dwb_stb_o, 0);
        chk("spurious ena", ena_o, 1);

        cyc(1, 0, 0, 0, 0, 1, 1, 4'd5, 0, 0);
        chk("put stb", cwb_stb_o, 1);
        chk("put adr", cwb_adr_o, 5);
        chk("put wre", cwb_wre_o, 1);
        chk("put sel_ma", sel_ma_o, 0);
        chk("put dwb_stb", dwb_stb_o, 0);
        idle(1, 0);
        chk("put wrong ack", cwb_stb_o, 1);
        chk("put wrong ack ena", ena_o, 0);
        idle(0, 1);
        chk("put done stb", cwb_stb_o, 0);
        chk("put done ena", ena_o, 1);

`ifdef AEMB2_BUS_TIMEOUT_EN
        cyc(1, 1, 0, 2'd2, 32'h100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0, 0);
            chk("tmo wait stb", dwb_stb_o, 1);
        end
        idle(0, 0);
        chk("tmo stb", dwb_stb_o, 0);
        chk("tmo err", err_o, 1);
        chk("tmo ena", ena_o, 1);
        idle(0, 0);
        chk("tmo err pulse", err_o, 0);
`endif

        cyc(1, 1, 0, 2'd2, 32'h40, 0, 0, 0, 0, 0);
        chk("mid stb", dwb_stb_o, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid rst stb", dwb_stb_o, 0);
        chk("mid rst ena", ena_o, 1);
        chk("mid rst sel_ma", sel_ma_o, 0);
        idle(0, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 63) != 0);
            mem_req_i = ($urandom_range(0, 3) == 0);
            mem_we_i = 1'($urandom);
            mem_siz_i = 2'($urandom);
            mem_adr_i = $urandom;
            fsl_req_i = ($urandom_range(0, 3) == 0);
            fsl_we_i = 1'($urandom);
            fsl_id_i = 4'($urandom);
            dwb_ack_i = ($urandom_range(0, 2) == 0);
            cwb_ack_i = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk_i);
        rst_i = 1; mem_req_i = 0; fsl_req_i = 0;
        dwb_ack_i = 0; cwb_ack_i = 0;
        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aemb2_bus_ctrl.md
# aemb2_bus_ctrl

Bus-cycle sequencer for the AEMB2 memory stage. It launches data-bus (DWB) and FSL (CWB) cycles for load/store/get/put instructions and holds the pipeline enable low until the slave acknowledges. It also produces the byte-select code consumed by the register-file load resizer and the thread-phase bit that banks the register file. It sits between the operand-fetch decode and the register file/bus pins.

## Interface
- TXE, 1, thread extension: 1 = phase toggles each enabled cycle, 0 = phase fixed at 0
- TMO, 255, timeout limit in cycles (used only with AEMB2_BUS_TIMEOUT_EN), 8-bit
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  one clock; reset is synchronous and active-low
- mem_req_i  in  1  load/store request from OF, sampled only when ena_o=1
- mem_we_i  in  1  1 = store, 0 = load
- mem_siz_i  in  2  0 byte, 1 half, 2 word, 3 treated as word
- mem_adr_i  in  32  effective address
- fsl_req_i  in  1  get/put request, sampled only when ena_o=1
- fsl_we_i  in  1  1 = put, 0 = get
- fsl_id_i  in  4  FSL channel
- dwb_adr_o  out  30  word address [31:2]
- dwb_stb_o / dwb_wre_o  out  1  strobe / write
- dwb_sel_o  out  4  byte lanes
- dwb_ack_i  in  1  DWB acknowledge
- cwb_adr_o  out  4  FSL channel
- cwb_stb_o / cwb_wre_o  out  1  strobe / write
- cwb_ack_i  in  1  CWB acknowledge
- ena_o  out  1  pipeline enable (drives regf ena_i)
- pha_o  out  1  thread phase (drives regf pha_i)
- sel_ma_o  out  4  select code for load resizer
- err_o  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, DBUS, CBUS. ena_o = (state==IDLE).
- IDLE, mem_req_i=1 → DBUS; register adr, we, sel; dwb_stb_o=1 next cycle.
- IDLE, fsl_req_i=1, mem_req_i=0 → CBUS; cwb_stb_o=1, cwb_adr_o=fsl_id_i.
- Both requests at once: mem wins, the FSL request is dropped. The decoder never issues both.
- DBUS/CBUS: hold strobe, address, we and sel stable. On the matching ack: strobe 0 and state IDLE at the next edge.
- Acks in IDLE, or the wrong bus's ack, are ignored.
- Select encoding (big-endian), registered with the request:
  - byte: adr[1:0] 0→8, 1→4, 2→2, 3→1
  - half: adr[1]=0→C, 1→3
  - word: F
- dwb_sel_o equals the select code. sel_ma_o takes the select code for DWB requests and 0 for FSL requests.
- sel_ma_o updates only on a sampled request and holds otherwise.
- pha_o toggles on every edge where ena_o=1, when TXE=1. It is constant 0 when TXE=0.
- Reset (rst_i=0 at an edge): state IDLE, all strobes/wre 0, adr outputs 0, sel outputs 0, pha_o 0, err_o 0. ena_o therefore reads 1.
- Reset mid-cycle drops the strobe at that edge with no ack wait.

## Timing
- Request edge N → strobe high in cycle N+1.
- Ack sampled high at edge M → strobe low and ena_o high from M onward.
- Minimum stall is 1 cycle (ack in first strobe cycle). ena_o stays low while the strobe is high.
- Data latching is done by the register file on ack; this block never touches data.

## Configuration
- AEMB2_BUS_TIMEOUT_EN defined:
  - An 8-bit counter clears on strobe launch and increments each strobe cycle without ack.
  - When it reaches TMO: strobe drops, state goes IDLE, err_o pulses high for one cycle.
  - An ack on the same edge as the timeout wins, with no error.
- AEMB2_BUS_TIMEOUT_EN undefined: no counter, cycles wait indefinitely, err_o tied 0.

## Test plan
- Reset: rst_i=0 for 2 cycles → all strobes 0, ena_o=1, pha_o=0, sel_ma_o=0.
- Byte load, adr=0x1003, ack after 3 strobe cycles:
  - dwb_adr_o=0x400, dwb_sel_o=1, sel_ma_o=1
  - ena_o low for 3 cycles, strobe low after the ack edge
- Half store, adr=0x22, immediate ack → dwb_wre_o=1, dwb_sel_o=3, one stall cycle. Spurious dwb_ack_i in IDLE → no effect.
- FSL put on id 5 raised together with mem_req_i=0 → cwb_adr_o=5, cwb_wre_o=1, sel_ma_o=0. A dwb_ack_i during CBUS does not end the cycle.
- TXE=1: 4 enabled cycles → pha_o 0,1,0,1; the phase holds during a stall.
- With AEMB2_BUS_TIMEOUT_EN, TMO=4, no ack → strobe drops after 4 cycles, err_o pulses once, ena_o returns to 1. Reset asserted mid-cycle → strobe 0 next edge.
